// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive-side message assembler.
package uart_pkg;

  typedef logic [7:0] uart_byte_t;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } msg_state_e;

  localparam int UART_BITS_PER_CHAR = 10;

endpackage

// File: rtl/uart_rx_msg_assembler.sv
// Packs MSG_BYTES consecutive UartRx bytes into one word behind a valid/ready port.
// Optional stale-partial-word discard is enabled by defining UART_RX_MSG_TIMEOUT_EN.
module uart_rx_msg_assembler
  import uart_pkg::*;
#(
  parameter int MSG_BYTES     = 13,
  parameter int CLOCK_RATE    = 100_000,
  parameter int BAUD_RATE     = 9600,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  uart_byte_t                       rx_data,
  input  logic                             rx_valid,
  output logic [MSG_BYTES*8-1:0]           msg_data,
  output logic                             msg_valid,
  input  logic                             msg_ready,
  output logic [$clog2(MSG_BYTES+1)-1:0]   byte_count,
  output logic                             overrun,
  input  logic                             clr_overrun,
  output logic                             timeout_err
);

  // Handshake: msg_data is transferred on a clk edge where msg_valid && msg_ready.
  // Once msg_valid is high, msg_valid and msg_data stay stable until that edge.

  localparam int W   = MSG_BYTES * 8;
  localparam int SW  = (MSG_BYTES > 1) ? W - 8 : 8;
  localparam int BCW = $clog2(MSG_BYTES + 1);
  localparam logic [BCW-1:0] LAST_IDX = BCW'(MSG_BYTES - 1);

  msg_state_e     state;
  logic [SW-1:0]  shreg;
  logic [W-1:0]   shift_word;
  logic [BCW-1:0] base_count;
  logic           accept;
  logic           word_done;

  // shreg holds only the pending older bytes; the newest byte comes straight from rx_data.
  generate
    if (MSG_BYTES == 1) begin : g_single
      assign shift_word = rx_data;
    end else begin : g_multi
      assign shift_word = {shreg, rx_data};
    end
  endgenerate

  // In HOLD a byte is only taken when the held word leaves in the same cycle,
  // in which case it starts a fresh word.
  always_comb begin
    accept     = 1'b0;
    base_count = byte_count;
    if (state == HOLD) begin
      accept     = rx_valid && msg_ready;
      base_count = '0;
    end else begin
      accept     = rx_valid;
    end
    word_done = accept && (base_count == LAST_IDX);
  end

`ifdef UART_RX_MSG_TIMEOUT_EN
  localparam longint TO_RAW = longint'(TIMEOUT_BYTES) * UART_BITS_PER_CHAR
                              * CLOCK_RATE / BAUD_RATE;
  localparam int TIMEOUT_CYCLES = (TO_RAW < 1) ? 1 : int'(TO_RAW);
  localparam int GW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GW-1:0] TO_LAST = GW'(TIMEOUT_CYCLES - 1);

  logic [GW-1:0] gap_cnt;
  logic          timeout_q;

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      shreg      <= '0;
      msg_data   <= '0;
      msg_valid  <= 1'b0;
      byte_count <= '0;
      overrun    <= 1'b0;
`ifdef UART_RX_MSG_TIMEOUT_EN
      gap_cnt    <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      if (clr_overrun) begin
        overrun <= 1'b0;
      end
      if (rx_valid && !accept) begin
        overrun <= 1'b1;
      end

      if (state == HOLD && msg_ready) begin
        msg_valid <= 1'b0;
        state     <= COLLECT;
      end

      if (accept) begin
        if (word_done) begin
          msg_data   <= shift_word;
          msg_valid  <= 1'b1;
          byte_count <= '0;
          shreg      <= '0;
          state      <= HOLD;
        end else begin
          shreg      <= shift_word[SW-1:0];
          byte_count <= base_count + 1'b1;
        end
      end

`ifdef UART_RX_MSG_TIMEOUT_EN
      timeout_q <= 1'b0;
      // A strobe on the expiry cycle is accepted above and simply restarts the gap.
      if (state != COLLECT || byte_count == '0 || rx_valid) begin
        gap_cnt <= '0;
      end else if (gap_cnt == TO_LAST) begin
        gap_cnt    <= '0;
        byte_count <= '0;
        shreg      <= '0;
        timeout_q  <= 1'b1;
      end else begin
        gap_cnt <= gap_cnt + 1'b1;
      end
`endif
    end
  end

endmodule
